sm_trace_buf: RTL and testbench
===============================

Name: sm_trace_buf

Overview:
- Parametrised on-chip execution trace recorder for the sm_cpu core, instantiated alongside sm_top.
- Each enabled CPU cycle it captures {cycle index, pc, instr} into a circular buffer of DEPTH entries.
- Capture freezes on a programmable PC trigger (plus POST_TRIG further entries) or on a cycle timeout.
- The frozen window is read back oldest-first through an address port.
- Replaces free-running, print-only cycle monitoring with a hardware-resident, triggerable history.

Parameters:
- DEPTH, 16: buffer entries; power of two, at least 2.
- ADDR_W, 4: log2(DEPTH).
- DATA_W, 32: width of pc and instr.
- CYCLE_W, 16: width of the cycle index.
- POST_TRIG, 8: entries captured after the trigger entry; 0 to DEPTH-1.
- TIMEOUT, 256: number of enabled cycles after arm at which capture stops; must be less than 2^CYCLE_W.

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- en, in, 1: CPU cycle valid (CPU clock enable); samples only when high.
- pc, in, DATA_W: current PC (word address).
- instr, in, DATA_W: current instruction.
- arm, in, 1: single-cycle pulse that clears and starts capture.
- trig_en, in, 1: enables PC-match trigger.
- trig_pc, in, DATA_W: PC value to trigger on.
- rd_addr, in, ADDR_W: logical read index; 0 is the oldest entry.
- rd_pc, out, DATA_W: pc of the addressed entry.
- rd_instr, out, DATA_W: instr of the addressed entry.
- rd_cycle, out, CYCLE_W: cycle index of the addressed entry.
- state, out, 2: 0 IDLE, 1 ARMED, 2 POST, 3 FROZEN.
- count, out, ADDR_W+1: valid entries, 0..DEPTH.
- timeout, out, 1: capture ended by timeout.
- trig_hit, out, 1: capture ended by trigger.

Behaviour:
- Reset: state IDLE; wr_ptr, count, cycle, post counter, timeout, trig_hit, rd_pc, rd_instr and rd_cycle all 0. Memory contents are not cleared.
- IDLE: no capture. arm moves to ARMED.
- ARMED, on each cycle with en=1:
  - write {cycle, pc, instr} at wr_ptr; wr_ptr = wr_ptr+1 mod DEPTH; count saturates at DEPTH; cycle increments.
  - en=0: nothing changes, including the cycle counter.
- Trigger: in ARMED with en=1, trig_en=1 and pc==trig_pc:
  - the entry is written as normal; post counter loads POST_TRIG; trig_hit is set.
  - state goes to POST, or directly to FROZEN if POST_TRIG=0.
- POST, on each cycle with en=1: write the entry, decrement the post counter. When the post counter reaches 0 after a write, go to FROZEN. Further pc matches are ignored.
- Timeout: in ARMED or POST, an en=1 cycle whose cycle value equals TIMEOUT-1 is written, then the block goes to FROZEN with timeout=1.
  - If a trigger fires on the same cycle, trig_hit is also set and the block still freezes.
- FROZEN: no writes. Outputs hold. Only arm or rst leaves this state.
- arm in any state:
  - clears wr_ptr, count, cycle, timeout and trig_hit; enters ARMED.
  - arm takes priority over en on the same cycle; that cycle is not captured.
- Readout is valid in every state:
  - physical index = (wr_ptr - count + rd_addr) mod DEPTH.
  - Registered, 1-cycle latency: rd_* reflect the rd_addr sampled at the previous edge.
  - If rd_addr >= count, rd_* = 0.
  - Reading while capture is running returns a coherent entry; read uses pre-write pointer values.
- Wrap-around: once count=DEPTH, new writes overwrite the oldest entry, and logical index 0 follows the overwrite.
- Reset mid-capture behaves exactly as reset from idle.

Decomposition:
- Shared package sm_trace_pkg: state encoding constants (S_IDLE, S_ARMED, S_POST, S_FROZEN) and the entry field layout (cycle, pc and instr offsets within a CYCLE_W+2*DATA_W word).
- One sub-module, sm_trace_ram: simple dual-port memory with DEPTH x (CYCLE_W+2*DATA_W) entries, one synchronous write port, one registered read port.
- FSM, pointers and counters stay in sm_trace_buf.

Test Plan:
- Reset, then rd_addr=0 → state=0, count=0, rd_pc=0, rd_instr=0, timeout=0.
- arm, en=1 every cycle with pc=0,1,2,… and trig_en=0; after 5 cycles read addresses 0..4 → count=5, rd_pc=0..4, rd_cycle=0..4, state=1.
- DEPTH=16, 20 enabled cycles with pc=0..19 → count=16; rd_addr=0 gives pc=4/cycle=4; rd_addr=15 gives pc=19.
- trig_pc=10, trig_en=1, POST_TRIG=3, pc ramps 0..30 → state=3, trig_hit=1, newest entry pc=13, pc 14 and later never captured.
- TIMEOUT=8, trig_en=0, en toggling 1,0,1,0… → freezes after the 8th enabled cycle; timeout=1; count=8; last rd_cycle=7.
- Frozen buffer, then arm with en=1 and pc matching trig_pc on the same cycle → state=1, count=0, trig_hit=0. The next en cycle is captured with cycle=0; this cycle's pc match triggers normally.

Source files
------------

// File: rtl/sm_trace_pkg.sv
// Shared definitions for the sm_cpu execution trace recorder:
// the capture state encoding and the bit layout of one stored entry.
package sm_trace_pkg;

   // Capture state, encoded exactly as it appears on the state output.
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ARMED  = 2'd1,
      S_POST   = 2'd2,
      S_FROZEN = 2'd3
   } state_e;

   // One entry is packed as {cycle, pc, instr}, instr in the least significant bits.
   localparam int INSTR_LSB = 0;

   function automatic int pc_lsb(input int data_w);
      return data_w;
   endfunction

   function automatic int cycle_lsb(input int data_w);
      return 2 * data_w;
   endfunction

   function automatic int entry_w(input int data_w, input int cycle_w);
      return cycle_w + 2 * data_w;
   endfunction

endpackage

// File: rtl/sm_trace_buf_if.sv
// Capture and readout signals of the trace recorder, bundled as one bus.
// master: the CPU-side logic that feeds samples and reads the history.
// slave:  the trace recorder itself.
interface sm_trace_buf_if
   import sm_trace_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int CYCLE_W = 16,
   parameter int ADDR_W  = 4
) ();

   // capture side
   logic                en;
   logic [DATA_W-1:0]   pc;
   logic [DATA_W-1:0]   instr;
   logic                arm;
   logic                trig_en;
   logic [DATA_W-1:0]   trig_pc;

   // readout side
   logic [ADDR_W-1:0]   rd_addr;
   logic [DATA_W-1:0]   rd_pc;
   logic [DATA_W-1:0]   rd_instr;
   logic [CYCLE_W-1:0]  rd_cycle;

   // status
   state_e              state;
   logic [ADDR_W:0]     count;
   logic                timeout;
   logic                trig_hit;

   modport master (
      output en, pc, instr, arm, trig_en, trig_pc, rd_addr,
      input  rd_pc, rd_instr, rd_cycle, state, count, timeout, trig_hit
   );

   modport slave (
      input  en, pc, instr, arm, trig_en, trig_pc, rd_addr,
      output rd_pc, rd_instr, rd_cycle, state, count, timeout, trig_hit
   );

endinterface

// File: rtl/sm_trace_ram.sv
// Simple dual-port entry store for the trace recorder: one synchronous
// write port and one read port with a registered output.
module sm_trace_ram #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4,
   parameter int WIDTH  = 64
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WIDTH-1:0]  wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WIDTH-1:0]  rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Write the new entry and register the addressed entry.
   // NOTE: the array has no reset; the recorder masks every entry beyond
   // count, so stale contents are never visible and the array maps to RAM.
   // A read of the slot being overwritten on the same edge returns the old
   // entry, which is what keeps a read during capture coherent.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sm_trace_buf.sv
// Execution trace recorder for the sm_cpu core. Every enabled CPU cycle
// while armed stores {cycle index, pc, instr} in a circular buffer. Capture
// freezes POST_TRIG entries after a PC match, or when the cycle index
// reaches TIMEOUT-1. The held window is read oldest-first by logical index.
module sm_trace_buf
   import sm_trace_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int ADDR_W    = 4,
   parameter int DATA_W    = 32,
   parameter int CYCLE_W   = 16,
   parameter int POST_TRIG = 8,
   parameter int TIMEOUT   = 256
) (
   input  logic          clk,
   input  logic          rst,
   sm_trace_buf_if.slave bus
);

   localparam int ENTRY_W = entry_w(DATA_W, CYCLE_W);
   localparam int PC_LSB  = pc_lsb(DATA_W);
   localparam int CYC_LSB = cycle_lsb(DATA_W);

   localparam logic [ADDR_W:0]    FULL_COUNT = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0]    COUNT_ONE  = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0]  ADDR_ONE   = ADDR_W'(1);
   localparam logic [ADDR_W-1:0]  POST_LOAD  = ADDR_W'(POST_TRIG);
   localparam logic [CYCLE_W-1:0] CYCLE_ONE  = CYCLE_W'(1);
   localparam logic [CYCLE_W-1:0] LAST_CYCLE = CYCLE_W'(TIMEOUT - 1);

   state_e              state_q,    state_d;
   logic [ADDR_W-1:0]   wr_ptr_q,   wr_ptr_d;
   logic [ADDR_W:0]     count_q,    count_d;
   logic [CYCLE_W-1:0]  cycle_q,    cycle_d;
   logic [ADDR_W-1:0]   post_q,     post_d;
   logic                timeout_q,  timeout_d;
   logic                trig_hit_q, trig_hit_d;
   logic                rd_valid_q;

   logic                capture;
   logic                trig_match;
   logic                last_cycle;
   logic [ENTRY_W-1:0]  entry_wdata;
   logic [ENTRY_W-1:0]  entry_rdata;
   logic [ADDR_W-1:0]   rd_phys;
   logic                rd_in_window;

   // arm wins over en, so the arming cycle itself is never stored.
   assign capture    = ((state_q == S_ARMED) || (state_q == S_POST)) && bus.en && !bus.arm;
   // Only the first match counts; matches during the post window are ignored.
   assign trig_match = (state_q == S_ARMED) && bus.trig_en && (bus.pc == bus.trig_pc);
   assign last_cycle = (cycle_q == LAST_CYCLE);

   // Capture FSM plus pointer, fill, cycle and post-trigger counters.
   // NOTE: every _d is given its hold value first, so any path that does not
   // assign it keeps the register and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      cycle_d    = cycle_q;
      post_d     = post_q;
      timeout_d  = timeout_q;
      trig_hit_d = trig_hit_q;

      if (bus.arm) begin
         state_d    = S_ARMED;
         wr_ptr_d   = '0;
         count_d    = '0;
         cycle_d    = '0;
         timeout_d  = 1'b0;
         trig_hit_d = 1'b0;
      end else if (capture) begin
         wr_ptr_d = wr_ptr_q + ADDR_ONE;
         cycle_d  = cycle_q + CYCLE_ONE;
         if (count_q != FULL_COUNT) begin
            count_d = count_q + COUNT_ONE;
         end

         if (state_q == S_POST) begin
            post_d = post_q - ADDR_ONE;
            if (post_q == ADDR_ONE) begin
               state_d = S_FROZEN;
            end
         end else if (trig_match) begin
            trig_hit_d = 1'b1;
            post_d     = POST_LOAD;
            state_d    = (POST_TRIG == 0) ? S_FROZEN : S_POST;
         end

         // The timeout freeze overrides whatever the trigger decided.
         if (last_cycle) begin
            timeout_d = 1'b1;
            state_d   = S_FROZEN;
         end
      end
   end

   // State and counter registers with synchronous reset.
   // NOTE: registers are written with <= so every flop samples the values
   // from before this edge, regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         cycle_q    <= '0;
         post_q     <= '0;
         timeout_q  <= 1'b0;
         trig_hit_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         cycle_q    <= cycle_d;
         post_q     <= post_d;
         timeout_q  <= timeout_d;
         trig_hit_q <= trig_hit_d;
      end
   end

   // Pack the current sample into the entry layout.
   always_comb begin
      entry_wdata = '0;
      entry_wdata[CYC_LSB   +: CYCLE_W] = cycle_q;
      entry_wdata[PC_LSB    +: DATA_W]  = bus.pc;
      entry_wdata[INSTR_LSB +: DATA_W]  = bus.instr;
   end

   // Logical index 0 is the oldest entry, count slots behind the write pointer.
   // The pre-write pointer and count are used so a read alongside a write
   // still addresses the window as it stood before this cycle.
   assign rd_phys      = wr_ptr_q - count_q[ADDR_W-1:0] + bus.rd_addr;
   assign rd_in_window = ({1'b0, bus.rd_addr} < count_q);

   sm_trace_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .WIDTH  (ENTRY_W)
   ) u_ram (
      .clk     (clk),
      .we_i    (capture),
      .waddr_i (wr_ptr_q),
      .wdata_i (entry_wdata),
      .raddr_i (rd_phys),
      .rdata_o (entry_rdata)
   );

   // Remember whether the registered read lies inside the valid window.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_in_window;
      end
   end

   assign bus.rd_pc    = rd_valid_q ? entry_rdata[PC_LSB    +: DATA_W]  : '0;
   assign bus.rd_instr = rd_valid_q ? entry_rdata[INSTR_LSB +: DATA_W]  : '0;
   assign bus.rd_cycle = rd_valid_q ? entry_rdata[CYC_LSB   +: CYCLE_W] : '0;
   assign bus.state    = state_q;
   assign bus.count    = count_q;
   assign bus.timeout  = timeout_q;
   assign bus.trig_hit = trig_hit_q;

endmodule

// File: tb/tb_sm_trace_buf.sv
// Scoreboard bench for sm_trace_buf. Two recorders run side by side:
//   index 0: DEPTH=16, POST_TRIG=3, TIMEOUT=256
//   index 1: DEPTH=16, POST_TRIG=0, TIMEOUT=8
// Each read request pushes its hand-computed response; a monitor pops and
// compares one cycle later when the registered readout is presented.
module tb_sm_trace_buf;
   import sm_trace_pkg::*;

   localparam int DW = 32;
   localparam int CW = 16;
   localparam int AW = 4;
   localparam int VW = 2 * DW + CW + 2 + (AW + 1) + 2;
   localparam logic [31:0] IBASE = 32'h1000_0000;

   typedef struct {
      int              d;
      string           name;
      logic [VW-1:0]   v;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // stimulus, one slot per recorder
   logic          rst_s      [2];
   logic          en_s       [2];
   logic          arm_s      [2];
   logic          trig_en_s  [2];
   logic [DW-1:0] pc_s       [2];
   logic [DW-1:0] instr_s    [2];
   logic [DW-1:0] trig_pc_s  [2];
   logic [AW-1:0] rd_addr_s  [2];
   logic          req_s      [2];

   // observed outputs
   logic [DW-1:0] rd_pc_o    [2];
   logic [DW-1:0] rd_instr_o [2];
   logic [CW-1:0] rd_cycle_o [2];
   logic [1:0]    state_o    [2];
   logic [AW:0]   count_o    [2];
   logic          timeout_o  [2];
   logic          trig_hit_o [2];

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   logic pend_q = 1'b0;
   logic chk_drain = 1'b0;

   sm_trace_buf_if #(.DATA_W(DW), .CYCLE_W(CW), .ADDR_W(AW)) bus_a ();
   sm_trace_buf_if #(.DATA_W(DW), .CYCLE_W(CW), .ADDR_W(AW)) bus_b ();

   assign bus_a.en      = en_s[0];
   assign bus_a.pc      = pc_s[0];
   assign bus_a.instr   = instr_s[0];
   assign bus_a.arm     = arm_s[0];
   assign bus_a.trig_en = trig_en_s[0];
   assign bus_a.trig_pc = trig_pc_s[0];
   assign bus_a.rd_addr = rd_addr_s[0];
   assign bus_b.en      = en_s[1];
   assign bus_b.pc      = pc_s[1];
   assign bus_b.instr   = instr_s[1];
   assign bus_b.arm     = arm_s[1];
   assign bus_b.trig_en = trig_en_s[1];
   assign bus_b.trig_pc = trig_pc_s[1];
   assign bus_b.rd_addr = rd_addr_s[1];

   assign rd_pc_o[0]    = bus_a.rd_pc;
   assign rd_instr_o[0] = bus_a.rd_instr;
   assign rd_cycle_o[0] = bus_a.rd_cycle;
   assign state_o[0]    = bus_a.state;
   assign count_o[0]    = bus_a.count;
   assign timeout_o[0]  = bus_a.timeout;
   assign trig_hit_o[0] = bus_a.trig_hit;
   assign rd_pc_o[1]    = bus_b.rd_pc;
   assign rd_instr_o[1] = bus_b.rd_instr;
   assign rd_cycle_o[1] = bus_b.rd_cycle;
   assign state_o[1]    = bus_b.state;
   assign count_o[1]    = bus_b.count;
   assign timeout_o[1]  = bus_b.timeout;
   assign trig_hit_o[1] = bus_b.trig_hit;

   sm_trace_buf #(
      .DEPTH(16), .ADDR_W(AW), .DATA_W(DW), .CYCLE_W(CW), .POST_TRIG(3), .TIMEOUT(256)
   ) dut_a (
      .clk (clk),
      .rst (rst_s[0]),
      .bus (bus_a.slave)
   );

   sm_trace_buf #(
      .DEPTH(16), .ADDR_W(AW), .DATA_W(DW), .CYCLE_W(CW), .POST_TRIG(0), .TIMEOUT(8)
   ) dut_b (
      .clk (clk),
      .rst (rst_s[1]),
      .bus (bus_b.slave)
   );

   function automatic logic [VW-1:0] pack(input logic [DW-1:0] p, input logic [DW-1:0] i,
                                           input logic [CW-1:0] c, input logic [1:0] st,
                                           input logic [AW:0] cnt, input logic to, input logic th);
      return {p, i, c, st, cnt, to, th};
   endfunction

   task automatic check(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: actual {pc,instr,cyc,st,cnt,to,th}=%h required=%h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int d, input logic e, input logic [DW-1:0] p);
      en_s[d]    = e;
      pc_s[d]    = p;
      instr_s[d] = IBASE | p;
      tick();
   endtask

   task automatic do_arm(input int d);
      arm_s[d] = 1'b1;
      en_s[d]  = 1'b0;
      tick();
      arm_s[d] = 1'b0;
   endtask

   // Issue one read; v=0 means the index is outside the window (all-zero data).
   task automatic rd(input int d, input string name, input logic [AW-1:0] a, input logic v,
                     input logic [DW-1:0] p, input logic [CW-1:0] c, input logic [1:0] st,
                     input logic [AW:0] cnt, input logic to, input logic th);
      exp_t e;
      e.d    = d;
      e.name = name;
      e.v    = v ? pack(p, IBASE | p, c, st, cnt, to, th) : pack('0, '0, '0, st, cnt, to, th);
      sb.push_back(e);
      rd_addr_s[d] = a;
      req_s[d]     = 1'b1;
      tick();
      req_s[d]     = 1'b0;
   endtask

   // A request sampled at one edge is answered after that edge.
   always @(posedge clk) pend_q <= req_s[0] | req_s[1];

   // Monitor: compare each presented readout with the oldest expectation.
   always @(negedge clk) begin
      exp_t          e;
      logic [VW-1:0] got;
      if (pend_q) begin
         if (sb.size() == 0) begin
            check("sb_nonempty", VW'(sb.size()), VW'(1));
         end else begin
            e   = sb.pop_front();
            got = pack(rd_pc_o[e.d], rd_instr_o[e.d], rd_cycle_o[e.d], state_o[e.d],
                       count_o[e.d], timeout_o[e.d], trig_hit_o[e.d]);
            check(e.name, got, e.v);
         end
      end
      if (chk_drain) begin
         check("sb_drained", VW'(sb.size()), VW'(0));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst_s[d] = 1'b1; en_s[d] = 1'b0; arm_s[d] = 1'b0; trig_en_s[d] = 1'b0;
         pc_s[d] = '0; instr_s[d] = '0; trig_pc_s[d] = '0; rd_addr_s[d] = '0; req_s[d] = 1'b0;
      end
      repeat (3) tick();
      rst_s[0] = 1'b0;
      rst_s[1] = 1'b0;

      // reset state
      rd(0, "rst_a", 0, 0, 0, 0, 0, 0, 0, 0);
      rd(1, "rst_b", 0, 0, 0, 0, 0, 0, 0, 0);

      // five captures, read back in order, then one index past the fill
      do_arm(0);
      for (int k = 0; k < 5; k++) drive(0, 1'b1, DW'(k));
      en_s[0] = 1'b0;
      for (int k = 0; k < 5; k++) rd(0, "fill5", AW'(k), 1, DW'(k), CW'(k), 1, 5, 0, 0);
      rd(0, "fill5_beyond", 5, 0, 0, 0, 1, 5, 0, 0);

      // arm with en high: arming cycle not stored; then 20 captures wrap
      arm_s[0] = 1'b1; en_s[0] = 1'b1; pc_s[0] = 99; instr_s[0] = IBASE | 32'd99;
      tick();
      arm_s[0] = 1'b0;
      for (int k = 0; k < 20; k++) drive(0, 1'b1, DW'(k));
      en_s[0] = 1'b0;
      rd(0, "wrap_oldest", 0, 1, 4, 4, 1, 16, 0, 0);
      rd(0, "wrap_newest", 15, 1, 19, 19, 1, 16, 0, 0);
      // read the oldest slot on the same cycle it is overwritten by pc=20
      en_s[0] = 1'b1; pc_s[0] = 20; instr_s[0] = IBASE | 32'd20;
      rd(0, "rdw_oldest", 0, 1, 4, 4, 1, 16, 0, 0);
      en_s[0] = 1'b0;
      rd(0, "wrap2_oldest", 0, 1, 5, 5, 1, 16, 0, 0);
      rd(0, "wrap2_newest", 15, 1, 20, 20, 1, 16, 0, 0);

      // trigger at pc=10 with three post entries, pc keeps ramping to 30
      trig_en_s[0] = 1'b1; trig_pc_s[0] = 10;
      do_arm(0);
      for (int k = 0; k <= 30; k++) drive(0, 1'b1, DW'(k));
      en_s[0] = 1'b0; trig_en_s[0] = 1'b0;
      rd(0, "trig_newest", 13, 1, 13, 13, 3, 14, 0, 1);
      rd(0, "trig_oldest", 0, 1, 0, 0, 3, 14, 0, 1);
      rd(0, "trig_no_pc14", 14, 0, 0, 0, 3, 14, 0, 1);

      // reset in the middle of a capture
      do_arm(0);
      for (int k = 0; k < 3; k++) drive(0, 1'b1, DW'(k));
      rst_s[0] = 1'b1;
      tick();
      rst_s[0] = 1'b0; en_s[0] = 1'b0;
      rd(0, "mid_reset", 0, 0, 0, 0, 0, 0, 0, 0);

      // timeout after the 8th enabled cycle, en toggling
      do_arm(1);
      for (int k = 0; k < 10; k++) begin
         drive(1, 1'b1, DW'(100 + k));
         drive(1, 1'b0, DW'(100 + k));
      end
      rd(1, "tmo_last", 7, 1, 107, 7, 3, 8, 1, 0);
      rd(1, "tmo_first", 0, 1, 100, 0, 3, 8, 1, 0);
      rd(1, "tmo_beyond", 8, 0, 0, 0, 3, 8, 1, 0);

      // POST_TRIG=0: freeze on the trigger entry itself
      trig_en_s[1] = 1'b1; trig_pc_s[1] = 203;
      do_arm(1);
      for (int k = 0; k < 6; k++) drive(1, 1'b1, DW'(200 + k));
      en_s[1] = 1'b0;
      rd(1, "post0_trig", 3, 1, 203, 3, 3, 4, 0, 1);
      rd(1, "post0_beyond", 4, 0, 0, 0, 3, 4, 0, 1);

      // re-arm from FROZEN with en high and a matching pc on the same cycle
      arm_s[1] = 1'b1; en_s[1] = 1'b1; pc_s[1] = 203; instr_s[1] = IBASE | 32'd203;
      tick();
      arm_s[1] = 1'b0; en_s[1] = 1'b0;
      rd(1, "rearm_clear", 0, 0, 0, 0, 1, 0, 0, 0);
      drive(1, 1'b1, 203);
      en_s[1] = 1'b0;
      rd(1, "rearm_trig", 0, 1, 203, 0, 3, 1, 0, 1);

      // trigger and timeout on the same cycle
      trig_pc_s[1] = 307;
      do_arm(1);
      for (int k = 0; k < 10; k++) drive(1, 1'b1, DW'(300 + k));
      en_s[1] = 1'b0; trig_en_s[1] = 1'b0;
      rd(1, "both_last", 7, 1, 307, 7, 3, 8, 1, 1);
      rd(1, "both_first", 0, 1, 300, 0, 3, 8, 1, 1);

      repeat (2) tick();
      chk_drain = 1'b1;
      tick();
      chk_drain = 1'b0;
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
